// File: rtl/rv_core_pkg.sv
// Shared core constants and the write-back request layout used by the writer side
// of the register file write port.
package rv_core_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR   = 5;
    localparam int unsigned REG_CNT    = 32;
    localparam int unsigned X0_ADDR    = 0;

    localparam int unsigned WB_REQ_W   = REG_ADDR + DATA_WIDTH;

    typedef struct packed {
        logic [REG_ADDR-1:0]   rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load responses ahead of the register file write port.
// Head is combinational from storage; pushes when full and pops when empty are ignored.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register file writer: merges ALU results and buffered load responses onto one write
// port, drops x0 writes and tracks outstanding destination registers.
module reg_writeback_ctrl
    import rv_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = rv_core_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR   = rv_core_pkg::REG_ADDR,
    parameter int unsigned REG_CNT    = rv_core_pkg::REG_CNT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR-1:0]           issue_rd,
    input  logic                          alu_valid,
    input  logic [REG_ADDR-1:0]           alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REG_ADDR-1:0]           mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          wr_en,
    output logic [REG_ADDR-1:0]           wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [REG_CNT-1:0]            busy_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned ReqW = REG_ADDR + DATA_WIDTH;

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ReqW-1:0]       fifo_head;
    logic                  sel_valid;
    logic [REG_ADDR-1:0]   sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [REG_CNT-1:0]    busy_q, busy_d;

    // Readiness comes from the pre-edge count only, so a same-cycle pop never helps.
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && mem_ready;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_fifo #(
        .WIDTH (ReqW),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({mem_rd, mem_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Fixed priority: ALU first, then FIFO head; a continuous ALU stream starves loads.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_head[ReqW-1:DATA_WIDTH];
            sel_data  = fifo_head[DATA_WIDTH-1:0];
        end
    end

    // x0 entries are consumed but never reach the write port; address/data hold.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (sel_valid && (sel_rd != REG_ADDR'(X0_ADDR))) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Clear on the commit edge, then apply the set so a same-register re-issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != REG_ADDR'(X0_ADDR))) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[X0_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: stimulus queues expected writes, a negedge
// monitor matches every register file write against them in order.
module tb_reg_writeback_ctrl;
    import rv_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    wb_req_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    reg_writeback_ctrl #(
        .DATA_WIDTH (32),
        .REG_ADDR   (5),
        .REG_CNT    (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy_mask   (busy_mask),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wb_req_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {59'd0, wr_addr}, 64'hFFFF);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                check("wr_addr", {59'd0, wr_addr}, {59'd0, e.rd});
                check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        repeat (2) tick();
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_busy", {32'd0, busy_mask}, 64'd0);
        check("rst_count", {61'd0, fifo_count}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
        rst = 1'b0;
        tick();

        // T1 ALU path
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        tick();
        alu_valid = 0;
        check("t1_wr_en_e", {63'd0, wr_en}, 64'd1);
        tick();
        check("t1_wr_en_e1", {63'd0, wr_en}, 64'd0);

        // T2 x0 drop
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        tick();
        alu_valid = 0;
        check("t2_alu_x0", {63'd0, wr_en}, 64'd0);
        mem_valid = 1; mem_rd = 0; mem_data = 32'h5678;
        tick();
        mem_valid = 0;
        check("t2_count1", {61'd0, fifo_count}, 64'd1);
        tick();
        check("t2_mem_x0", {63'd0, wr_en}, 64'd0);
        check("t2_count0", {61'd0, fifo_count}, 64'd0);

        // T3 FIFO full and order under a continuous ALU stream
        alu_valid = 1; alu_rd = 1;
        mem_valid = 1;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + i;
            mem_rd   = 5'(2 + i);
            mem_data = 32'hB000_0000 + i;
            expect_wr(1, 32'hA000_0000 + i);
            tick();
        end
        check("t3_count4", {61'd0, fifo_count}, 64'd4);
        check("t3_not_ready", {63'd0, mem_ready}, 64'd0);
        alu_data = 32'hA000_0004; mem_rd = 6; mem_data = 32'hB000_0099;
        expect_wr(1, 32'hA000_0004);
        tick();
        check("t3_5th_dropped", {61'd0, fifo_count}, 64'd4);
        alu_valid = 0; mem_valid = 0;
        for (int i = 0; i < 4; i++) expect_wr(5'(2 + i), 32'hB000_0000 + i);
        repeat (5) tick();
        check("t3_drained", {61'd0, fifo_count}, 64'd0);

        // T4 scoreboard
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        check("t4_busy_set", {63'd0, busy_mask[7]}, 64'd1);
        mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
        expect_wr(7, 32'h77);
        tick();
        mem_valid = 0;
        check("t4_busy_queued", {63'd0, busy_mask[7]}, 64'd1);
        tick();
        check("t4_busy_wr_pending", {63'd0, busy_mask[7]}, 64'd1);
        tick();
        check("t4_busy_cleared", {63'd0, busy_mask[7]}, 64'd0);
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        mem_valid = 1; mem_rd = 7; mem_data = 32'h78;
        expect_wr(7, 32'h78);
        tick();
        mem_valid = 0;
        tick();
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        check("t4_set_wins", {63'd0, busy_mask[7]}, 64'd1);
        tick();
        check("t4_still_busy", {63'd0, busy_mask[7]}, 64'd1);

        // T5 reset mid-drain
        issue_valid = 1;
        for (int i = 0; i < 3; i++) begin
            issue_rd = 5'(9 + i);
            tick();
        end
        issue_valid = 0;
        alu_valid = 1; alu_rd = 0; mem_valid = 1;
        for (int i = 0; i < 3; i++) begin
            mem_rd = 5'(9 + i); mem_data = 32'hC000_0000 + i;
            tick();
        end
        alu_valid = 0; mem_valid = 0;
        check("t5_count3", {61'd0, fifo_count}, 64'd3);
        expect_wr(9, 32'hC000_0000);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("t5_rst_busy", {32'd0, busy_mask}, 64'd0);
        check("t5_rst_count", {61'd0, fifo_count}, 64'd0);
        check("t5_rst_ready", {63'd0, mem_ready}, 64'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t5_no_write", {63'd0, wr_en}, 64'd0);
        check("t5_still_empty", {61'd0, fifo_count}, 64'd0);

        // T6 simultaneous push and pop at count 2
        alu_valid = 1; alu_rd = 0; mem_valid = 1;
        for (int i = 0; i < 2; i++) begin
            mem_rd = 5'(12 + i); mem_data = 32'hD000_0000 + i;
            tick();
        end
        alu_valid = 0;
        check("t6_count2", {61'd0, fifo_count}, 64'd2);
        mem_rd = 14; mem_data = 32'hD000_0002;
        expect_wr(12, 32'hD000_0000);
        tick();
        mem_valid = 0;
        check("t6_count_held", {61'd0, fifo_count}, 64'd2);
        check("t6_head_written", {63'd0, wr_en}, 64'd1);
        expect_wr(13, 32'hD000_0001);
        expect_wr(14, 32'hD000_0002);
        repeat (3) tick();
        check("t6_drained", {61'd0, fifo_count}, 64'd0);

        repeat (2) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
